fifo_pop_port: RTL

Read-side controller for the 16-bit register-bank FIFO: the mirror of the per-stage write/push logic. It tracks occupancy from the write side's push strobe, drives the read address into the register bank, and prefetches one word into a registered output stage. Data is handed out with a valid/ready handshake. It sits between the FIFO storage (register stages loaded on push) and the downstream consumer.

---
 rtl/fifo_pop_port_if.sv | 28 ++
 rtl/fifo_pop_port.sv | 78 +++++++
 2 files changed

// File: rtl/fifo_pop_port_if.sv
// Read-side bundle between the pop controller, the register-bank storage and
// the downstream consumer. master = controller, slave = storage/consumer side.
interface fifo_pop_port_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
);
    logic             push;
    logic             full;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        input  push, rd_data, out_ready,
        output full, rd_addr, out_data, out_valid, empty, count, overflow, underflow
    );

    modport slave (
        output push, rd_data, out_ready,
        input  full, rd_addr, out_data, out_valid, empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_pop_port.sv
// Read-side controller for the register-bank FIFO: tracks occupancy from push,
// walks the read address and prefetches one word into a registered output stage.
module fifo_pop_port #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    fifo_pop_port_if.master bus
);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    rd_addr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] out_data_q;
    logic             overflow_q;
    logic             underflow_q;

    logic full;
    logic out_valid;
    logic accept;
    logic take;
    logic fetch;

    assign out_valid = (state == HOLD);
    assign full      = (count_q == CW'(DEPTH));
    assign accept    = bus.push && !full;
    assign take      = out_valid && bus.out_ready;
    // A slot frees when copied into the output stage, so refill in the drain cycle.
    assign fetch     = (count_q != CW'(0)) && (!out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            rd_addr_q   <= AW'(0);
            count_q     <= CW'(0);
            out_data_q  <= WIDTH'(0);
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.push && full;
            underflow_q <= bus.out_ready && !out_valid;

            case (state)
                EMPTY:   if (fetch) state <= HOLD;
                HOLD:    if (take && !fetch) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (fetch) begin
                out_data_q <= bus.rd_data;
                rd_addr_q  <= (rd_addr_q == AW'(DEPTH - 1)) ? AW'(0) : rd_addr_q + AW'(1);
            end

            if (accept && !fetch) begin
                count_q <= count_q + CW'(1);
            end else if (fetch && !accept) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign bus.full      = full;
    assign bus.empty     = (count_q == CW'(0)) && !out_valid;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.count     = count_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
